reg_sample_fifo: RTL and testbench

//   Synchronous FIFO that buffers the 8-bit sample stream produced by the
//   per-cycle D-register stage, so a slower or bursty consumer can drain it.

---
 rtl/reg_sample_fifo_if.sv | 32 +++
 rtl/reg_sample_fifo.sv | 78 +++++++
 tb/tb_reg_sample_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reg_sample_fifo_if.sv
// Bus bundle between the sample producer/consumer and reg_sample_fifo.
// The master drives write/read requests; the FIFO (slave) returns data and status.
interface reg_sample_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // wr_en/rd_en are requests, not handshakes: a write is accepted when
  // !full || rd_en, and a read is accepted when !empty. A rejected request
  // does not stall. It sets the sticky overflow or underflow flag instead.
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, empty, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, empty, full, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/reg_sample_fifo.sv
// Synchronous FIFO that buffers the per-cycle sample stream for a bursty consumer.
// Registered read data, occupancy count, and sticky overflow/underflow flags.
module reg_sample_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input logic              clk,
  input logic              rst,
  reg_sample_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] data_out_q;
  logic             overflow_q;
  logic             underflow_q;

  logic is_empty;
  logic is_full;
  logic rd_ok;
  logic wr_ok;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign rd_ok    = bus.rd_en && !is_empty;
  // A full FIFO is never empty, so a simultaneous read frees the slot this cycle.
  assign wr_ok    = bus.wr_en && (!is_full || bus.rd_en);

  // Storage is not reset; only entries behind a valid write are ever read.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        data_out_q <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count_q <= count_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (bus.wr_en && !wr_ok) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && !rd_ok) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.count       = count_q;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (count_q >= CW'(AF_LEVEL));
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_reg_sample_fifo.sv
// Directed + short random bench for reg_sample_fifo, checked against a
// queue-based reference model of the FIFO contents and sticky flags.
module tb_reg_sample_fifo;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  reg_sample_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_ovf;
  logic             exp_unf;
  int               checks   = 0;
  int               failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".count"},       32'(bus.count),       32'(n));
    check({tag, ".empty"},       32'(bus.empty),       32'(n == 0));
    check({tag, ".full"},        32'(bus.full),        32'(n == DEPTH));
    check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= AF_LEVEL));
    check({tag, ".data_out"},    32'(bus.data_out),    32'(exp_dout));
    check({tag, ".overflow"},    32'(bus.overflow),    32'(exp_ovf));
    check({tag, ".underflow"},   32'(bus.underflow),   32'(exp_unf));
  endtask

  // driver: one clock with the given requests, model updated in parallel
  task automatic step(input logic wr, input logic [WIDTH-1:0] din, input logic rd, input string tag);
    bit m_full, rd_ok, wr_ok;
    bus.wr_en   = wr;
    bus.data_in = din;
    bus.rd_en   = rd;
    m_full = (exp_q.size() == DEPTH);
    rd_ok  = rd && (exp_q.size() != 0);
    wr_ok  = wr && (!m_full || rd);
    if (wr && !wr_ok) exp_ovf = 1'b1;
    if (rd && !rd_ok) exp_unf = 1'b1;
    if (rd_ok) exp_dout = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(din);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input int cycles, input logic wr, input logic rd, input string tag);
    rst         = 1'b1;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.data_in = 8'h5A;
    repeat (cycles) @(posedge clk);
    #1;
    exp_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    exp_dout    = '0;
    exp_ovf     = 1'b0;
    exp_unf     = 1'b0;

    // 1. reset
    do_reset(2, 1'b0, 1'b0, "reset");

    // 2. three writes then three reads
    step(1'b1, 8'd5,   1'b0, "t2_wr0");
    step(1'b1, 8'd225, 1'b0, "t2_wr1");
    step(1'b1, 8'd250, 1'b0, "t2_wr2");
    step(1'b0, 8'd0,   1'b1, "t2_rd0");
    check("t2_first_out", 32'(bus.data_out), 32'd5);
    step(1'b0, 8'd0,   1'b1, "t2_rd1");
    step(1'b0, 8'd0,   1'b1, "t2_rd2");
    check("t2_last_out", 32'(bus.data_out), 32'd250);

    // 3. fill, then a dropped write
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0, "t3_fill");
    end
    step(1'b1, 8'hAA, 1'b0, "t3_drop");
    check("t3_overflow_set", 32'(bus.overflow), 32'd1);

    // 4. full with simultaneous read/write across pointer wrap
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h11, 1'b1, "t4_rw_full");
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, "t4_drain");
    end

    // 5. underflow, then simultaneous read/write while empty
    step(1'b0, 8'h00, 1'b1, "t5_unf");
    check("t5_underflow_set", 32'(bus.underflow), 32'd1);
    step(1'b1, 8'h33, 1'b1, "t5_rw_empty");
    step(1'b0, 8'h00, 1'b1, "t5_rd");
    check("t5_read_33", 32'(bus.data_out), 32'h33);

    // 6. reset during a read with entries queued
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b0, "t6_load");
    end
    do_reset(1, 1'b0, 1'b1, "t6_reset");
    step(1'b1, 8'h7E, 1'b0, "t6_wr");
    step(1'b0, 8'h00, 1'b1, "t6_rd");
    check("t6_read_7e", 32'(bus.data_out), 32'h7E);

    // short random mix
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
